// File: rtl/div_issue_if.sv
// Operand/result handshake bundle for div_issue_stage.
// master = operand source and result consumer, slave = the issue stage.
interface div_issue_if #(
    parameter int WIDTH = 4
);
    // Both channels use valid/ready: a beat transfers on a rising edge where
    // valid && ready; the sender holds valid and data stable until it does.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_dbz;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_dbz
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_dbz
    );
endinterface

// File: rtl/div_issue_stage.sv
// Operand FIFO + result register around a combinational divider.
// Optional macro DIV_ZERO_CHECK_EN: flag divide-by-zero and force quotient/remainder.
module div_issue_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    div_issue_if.slave                 bus,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_dividend [DEPTH];
    logic [WIDTH-1:0] mem_divisor  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             empty;
    logic             full;
    logic             push;
    logic             fire;
    logic             cap_dbz;
    logic [WIDTH-1:0] cap_quotient;
    logic [WIDTH-1:0] cap_remainder;

    assign empty        = (count == '0);
    assign full         = (count == FULL_COUNT);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign fire         = !empty && (!bus.out_valid || bus.out_ready);
    assign occupancy    = count;

    // Head is presented to the divider; zeros when empty keep its inputs quiet.
    assign div_dividend = empty ? '0 : mem_dividend[rd_ptr];
    assign div_divisor  = empty ? '0 : mem_divisor[rd_ptr];

    always_comb begin
        cap_dbz       = 1'b0;
        cap_quotient  = div_quotient;
        cap_remainder = div_remainder;
`ifdef DIV_ZERO_CHECK_EN
        if (div_divisor == '0) begin
            cap_dbz       = 1'b1;
            cap_quotient  = '1;
            cap_remainder = div_dividend;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dividend[wr_ptr] <= bus.in_dividend;
            mem_divisor[wr_ptr]  <= bus.in_divisor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.out_quotient  <= '0;
            bus.out_remainder <= '0;
            bus.out_dbz       <= 1'b0;
        end else if (fire) begin
            bus.out_valid     <= 1'b1;
            bus.out_quotient  <= cap_quotient;
            bus.out_remainder <= cap_remainder;
            bus.out_dbz       <= cap_dbz;
        end else if (bus.out_ready) begin
            bus.out_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_issue_stage.sv
// Bench for div_issue_stage: directed vectors, expected-result queue, negedge monitor.
// Build with or without DIV_ZERO_CHECK_EN; the divide-by-zero expectation follows it.
module tb_div_issue_stage;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 2 * WIDTH + 1;

    logic clk;
    logic rst_n;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    div_issue_if #(.WIDTH(WIDTH)) bus ();

    div_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .occupancy     (occupancy)
    );

    // Divider stand-in; a zero divisor yields (0,0) so an unforced capture is visible.
    always_comb begin
        div_quotient  = '0;
        div_remainder = '0;
        if (div_divisor != '0) begin
            div_quotient  = div_dividend / div_divisor;
            div_remainder = div_dividend % div_divisor;
        end
    end

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] res(input logic dbz, input logic [WIDTH-1:0] q,
                                          input logic [WIDTH-1:0] r);
        return {dbz, q, r};
    endfunction

    // driver: call at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RW-1:0] e);
        int cycles = 0;
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        while (!bus.in_ready && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stuck at 0 for %0d cycles", cycles);
        end else begin
            exp_q.push_back(e);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cycles = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        @(negedge clk);
        @(negedge clk);
        check("drain_complete", exp_q.size(), 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none",
                         {bus.out_dbz, bus.out_quotient, bus.out_remainder});
            end else begin
                check("result", {bus.out_dbz, bus.out_quotient, bus.out_remainder},
                      exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_dividend  = '0;
        bus.in_divisor   = '0;
        bus.out_ready    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_data", {bus.out_dbz, bus.out_quotient, bus.out_remainder}, 0);
        check("rst_div_ports", {div_dividend, div_divisor}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single ops with idle gaps, latency check
        push(4'd10, 4'd2, res(1'b0, 4'd5, 4'd0));
        check("lat_not_yet", bus.out_valid, 0);
        @(negedge clk);
        check("lat_valid", bus.out_valid, 1);
        repeat (2) @(negedge clk);
        push(4'd12, 4'd4, res(1'b0, 4'd3, 4'd0));
        @(negedge clk);
        check("lat_valid2", bus.out_valid, 1);
        repeat (2) @(negedge clk);
        push(4'd11, 4'd5, res(1'b0, 4'd2, 4'd1));
        wait_drain();
        check("idle_valid_low", bus.out_valid, 0);

        // back-to-back streaming
        push(4'd15, 4'd3, res(1'b0, 4'd5, 4'd0));
        check("stream_occ", occupancy <= 1, 1);
        push(4'd14, 4'd4, res(1'b0, 4'd3, 4'd2));
        check("stream_occ", occupancy <= 1, 1);
        check("stream_valid", bus.out_valid, 1);
        push(4'd7,  4'd2, res(1'b0, 4'd3, 4'd1));
        check("stream_valid", bus.out_valid, 1);
        push(4'd0,  4'd5, res(1'b0, 4'd0, 4'd0));
        check("stream_occ", occupancy <= 1, 1);
        push(4'd15, 4'd1, res(1'b0, 4'd15, 4'd0));
        check("stream_valid", bus.out_valid, 1);
        push(4'd3,  4'd7, res(1'b0, 4'd0, 4'd3));
        check("stream_occ", occupancy <= 1, 1);
        push(4'd8,  4'd8, res(1'b0, 4'd1, 4'd0));
        check("stream_valid", bus.out_valid, 1);
        push(4'd13, 4'd6, res(1'b0, 4'd2, 4'd1));
        check("stream_occ", occupancy <= 1, 1);
        wait_drain();

        // backpressure: first result parks in the output register, FIFO fills
        bus.out_ready = 1'b0;
        push(4'd10, 4'd2, res(1'b0, 4'd5, 4'd0));
        push(4'd9,  4'd3, res(1'b0, 4'd3, 4'd0));
        push(4'd13, 4'd4, res(1'b0, 4'd3, 4'd1));
        push(4'd6,  4'd5, res(1'b0, 4'd1, 4'd1));
        check("bp_not_full_yet", bus.in_ready, 1);
        push(4'd15, 4'd2, res(1'b0, 4'd7, 4'd1));
        check("bp_occupancy", occupancy, DEPTH);
        check("bp_in_ready_low", bus.in_ready, 0);
        fork
            push(4'd11, 4'd3, res(1'b0, 4'd3, 4'd2));
            begin
                for (int i = 0; i < 3; i++) begin
                    check("bp_hold", {bus.out_valid, bus.out_quotient, bus.out_remainder},
                          {1'b1, 4'd5, 4'd0});
                    check("bp_still_full", bus.in_ready, 0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
                @(negedge clk);
                check("bp_ready_rises", bus.in_ready, 1);
            end
        join
        wait_drain();

        // divide by zero plus operand boundaries
`ifdef DIV_ZERO_CHECK_EN
        push(4'd9, 4'd0, res(1'b1, 4'hF, 4'd9));
`else
        push(4'd9, 4'd0, res(1'b0, 4'd0, 4'd0));
`endif
        push(4'd15, 4'd15, res(1'b0, 4'd1, 4'd0));
        wait_drain();

        // reset mid-operation
        bus.out_ready = 1'b0;
        push(4'd12, 4'd3, res(1'b0, 4'd4, 4'd0));
        push(4'd7,  4'd7, res(1'b0, 4'd1, 4'd0));
        push(4'd5,  4'd2, res(1'b0, 4'd2, 4'd1));
        push(4'd14, 4'd5, res(1'b0, 4'd2, 4'd4));
        check("pre_rst_occ", occupancy, 3);
        check("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_div_ports", {div_dividend, div_divisor}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        push(4'd6, 4'd3, res(1'b0, 4'd2, 4'd0));
        wait_drain();
        repeat (4) @(negedge clk);

        check("total_results", n_pops, 3 + 8 + 6 + 2 + 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
